program_loader: RTL and testbench

- Boot stage directly upstream of the single-cycle MIPS core.
- Receives a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit instruction words.
- Writes each word into the write port of the instruction memory.
- Holds the processor in reset until the image is fully loaded, then releases it. The core then starts fetching from PC=0.

---
 rtl/program_loader.sv | 161 ++++++++++++++++
 tb/tb_program_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them to instruction memory,
// and holds the core in reset until the image is in. Optional build macro: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [7:0]            in_data_i,
  output logic                  in_ready_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  cpu_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           words_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [16:0]           CAPACITY = 17'((1 << ADDR_WIDTH) - BASE_ADDR);

  state_e                  state_q, state_d;
  logic [15:0]             n_q, n_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [31:0]             word_q, word_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             words_q, words_d;
  logic [15:0]             len_full;
  logic                    accept;
  logic                    in_ready;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]              xor_q, xor_d;
  localparam state_e       S_TAIL = S_CHECK;
`else
  localparam state_e       S_TAIL = S_DONE;
`endif

  // in_ready is a pure state decode so in_valid never reaches an output combinationally.
  always_comb begin
    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (state_q == S_CHECK) in_ready = 1'b1;
`endif
  end

  assign accept   = in_valid_i & in_ready;
  assign len_full = {n_q[15:8], in_data_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      addr_q  <= BASE;
      words_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      words_q <= words_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    words_d = words_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
    if (accept && state_q != S_CHECK) xor_d = xor_q ^ in_data_i;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_LEN_HI;
          cnt_d   = '0;
          addr_d  = BASE;
          words_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          n_d     = {in_data_i, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          n_d = len_full;
          if (len_full == 16'd0)                  state_d = S_TAIL;
          else if ({1'b0, len_full} > CAPACITY)   state_d = S_ERROR;
          else                                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], in_data_i};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        words_d = words_q + 16'd1;
        addr_d  = addr_q + 1'b1;
        state_d = (words_q + 16'd1 == n_q) ? S_TAIL : S_DATA;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (in_data_i == xor_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o     = in_ready;
  assign imem_we_o      = (state_q == S_WRITE);
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = word_q;
  assign cpu_reset_o    = (state_q != S_DONE);
  assign busy_o         = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                          (state_q == S_DATA)   || (state_q == S_WRITE);
  assign done_o         = (state_q == S_DONE);
  assign error_o        = (state_q == S_ERROR);
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Table-driven bench for program_loader with a write scoreboard; honours PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, cpu_reset, busy, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] words_loaded;

  int checks = 0;
  int fails  = 0;

  program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .cpu_reset_o(cpu_reset), .busy_o(busy), .done_o(done), .error_o(error),
    .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          gap;
    bit          mid_start;
    bit          exp_done;
    bit          exp_err;
    logic [15:0] exp_words;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard for memory writes; also checks in_ready/busy during the write cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(imem_addr), 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e.addr));
        check("write_data", imem_wdata, e.data);
      end
      check("ready_in_write", 32'(in_ready), 32'd0);
      check("busy_in_write", 32'(busy), 32'd1);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_end(input bit exp_err);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done || error) begin
        seen = 1'b1;
        check("cpu_reset_first_cycle", 32'(cpu_reset), exp_err ? 32'd1 : 32'd0);
      end
    end
    if (!seen) check("end_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] word_for(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  task automatic run_case(input vec_t v, input int idx);
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    pulse_start();
    send_byte(v.n[15:8], v.gap); x ^= v.n[15:8];
    send_byte(v.n[7:0],  v.gap); x ^= v.n[7:0];
    if (v.mid_start) pulse_start();
    if (!v.exp_err) begin
      for (int i = 0; i < int'(v.n); i++) begin
        w = word_for(v, i);
        exp_q.push_back({8'(i), w});
        for (int k = 3; k >= 0; k--) begin
          send_byte(w[k*8 +: 8], v.gap);
          x ^= w[k*8 +: 8];
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(x, v.gap);
`endif
    end
    in_valid = 1'b0;
    wait_end(v.exp_err);
    @(negedge clk);
    $display("case %0d: n=%0d done=%0b error=%0b words=%0d", idx, v.n, done, error, words_loaded);
    check("done", 32'(done), 32'(v.exp_done));
    check("error", 32'(error), 32'(v.exp_err));
    check("cpu_reset", 32'(cpu_reset), v.exp_err ? 32'd1 : 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("words_loaded", 32'(words_loaded), 32'(v.exp_words));
    check("writes_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'd2,   32'h20080005, 32'h01095020, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[1] = '{16'd2,   32'h20080005, 32'h01095020, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[2] = '{16'd0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[3] = '{16'd257, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[4] = '{16'd1,   32'hDEADBEEF, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[5] = '{16'd256, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd256};
    vecs[6] = '{16'd1,   32'hAABBCCDD, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 16'd1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_case(vecs[i], i);

    // Reset in the middle of word 0 after its third byte.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_imem_we", 32'(imem_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'd0);
    check("midrst_wdata", imem_wdata, 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_case(vecs[0], 7);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Bad checksum byte: 00 01 AA BB CC DD 00 must end in ERROR.
    pulse_start();
    exp_q.push_back({8'd0, 32'hAABBCCDD});
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    wait_end(1'b1);
    check("cksum_bad_error", 32'(error), 32'd1);
    check("cksum_bad_done", 32'(done), 32'd0);
    check("cksum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("cksum_bad_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
